// File: rtl/dcache_pkg.sv
// Shared definitions for the dcache memory-side blocks.
// Bus widths and the responder state encoding.
package dcache_pkg;

    localparam int ADDRBITS = 32;
    localparam int DATABITS = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RLAT   = 2'b01,
        RBURST = 2'b10,
        WBURST = 2'b11
    } mstate_e;

endpackage

// File: rtl/mem_sram.sv
// Single-port synchronous word RAM, write-first, registered read.
// The caller arbitrates between read and write use of the port.
module mem_sram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dcache_memresp.sv
// Memory-side burst responder for the dcache line interface.
// Streams read bursts from, and absorbs write bursts into, a local SRAM.
module dcache_memresp
    import dcache_pkg::*;
#(
    parameter int BURSTLEN    = 8,
    parameter int READ_LAT    = 2,
    parameter int MEMADDRBITS = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDRBITS-1:0] mem_addr,
    input  logic [DATABITS-1:0] mem_datain,
    input  logic                mem_rdreq,
    input  logic                mem_wrreq,
    output logic [DATABITS-1:0] mem_out,
    output logic                mem_valid,
    output logic [15:0]         mem_burstlen,
    output logic                mem_busy,
    output logic                mem_err
);

    localparam logic [15:0] BLEN     = 16'(BURSTLEN);
    localparam logic [15:0] LAT_LAST = 16'(READ_LAT - 1);

    mstate_e state, state_n;

    logic [MEMADDRBITS-1:0] rptr, rptr_n;
    logic [MEMADDRBITS-1:0] wptr, wptr_n;
    logic [MEMADDRBITS-1:0] req_addr;
    logic [15:0]            cnt, cnt_n;
    logic [15:0]            lat, lat_n;
    logic                   valid_n;
    logic                   err_n;

    logic                   sram_en;
    logic                   sram_we;
    logic [MEMADDRBITS-1:0] sram_addr;
    logic [DATABITS-1:0]    sram_rdata;

    logic unused_addr;

    assign req_addr     = mem_addr[MEMADDRBITS+1:2];
    assign unused_addr  = ^{mem_addr[ADDRBITS-1:MEMADDRBITS+2], mem_addr[1:0]};
    assign mem_burstlen = BLEN;
    assign mem_out      = mem_valid ? sram_rdata : '0;

    mem_sram #(
        .AW (MEMADDRBITS),
        .DW (DATABITS)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sram_we),
        .addr  (sram_addr),
        .wdata (mem_datain),
        .rdata (sram_rdata)
    );

    always_comb begin
        state_n   = state;
        rptr_n    = rptr;
        wptr_n    = wptr;
        cnt_n     = cnt;
        lat_n     = lat;
        valid_n   = 1'b0;
        err_n     = mem_err;
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = rptr;

        unique case (state)
            IDLE: begin
                if (mem_wrreq) begin
                    sram_en   = 1'b1;
                    sram_we   = 1'b1;
                    sram_addr = req_addr;
                    wptr_n    = req_addr + 1'b1;
                    cnt_n     = 16'd1;
                    if (BLEN != 16'd1)
                        state_n = WBURST;
                    if (mem_rdreq)
                        err_n = 1'b1;
                end else if (mem_rdreq) begin
                    rptr_n  = req_addr;
                    lat_n   = 16'd1;
                    state_n = RLAT;
                end
            end
            RLAT: begin
                // Read issued one cycle early: SRAM output is registered.
                if (lat == LAT_LAST) begin
                    sram_en   = 1'b1;
                    sram_addr = rptr;
                    rptr_n    = rptr + 1'b1;
                    cnt_n     = 16'd1;
                    valid_n   = 1'b1;
                    state_n   = RBURST;
                end else begin
                    lat_n = lat + 16'd1;
                end
            end
            RBURST: begin
                if (cnt == BLEN) begin
                    state_n = IDLE;
                end else begin
                    sram_en   = 1'b1;
                    sram_addr = rptr;
                    rptr_n    = rptr + 1'b1;
                    cnt_n     = cnt + 16'd1;
                    valid_n   = 1'b1;
                end
            end
            WBURST: begin
                sram_en   = 1'b1;
                sram_we   = 1'b1;
                sram_addr = wptr;
                wptr_n    = wptr + 1'b1;
                cnt_n     = cnt + 16'd1;
                if (cnt + 16'd1 == BLEN)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (state != IDLE && (mem_rdreq || mem_wrreq))
            err_n = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rptr      <= '0;
            wptr      <= '0;
            cnt       <= '0;
            lat       <= '0;
            mem_valid <= 1'b0;
            mem_busy  <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state     <= state_n;
            rptr      <= rptr_n;
            wptr      <= wptr_n;
            cnt       <= cnt_n;
            lat       <= lat_n;
            mem_valid <= valid_n;
            mem_busy  <= (state_n != IDLE);
            mem_err   <= err_n;
        end
    end

endmodule

// File: doc/dcache_memresp.md
# dcache_memresp

Memory-side responder for the data-cache line burst interface. Accepts single-cycle read and write burst requests from a cache line. Serves reads by streaming `BURSTLEN` consecutive words from an internal word-addressed SRAM after a fixed latency. Absorbs write bursts into the same SRAM. It sits between the dcache line controller and the backing store, and serves as both the system memory model and the behavioural target for cache verification.

## Interface
Parameters:
- `BURSTLEN`, 8: words per burst, 1..65535; driven constant on `mem_burstlen`.
- `READ_LAT`, 2: cycles from the `mem_rdreq` cycle to the first `mem_valid`; minimum 2.
- `MEMADDRBITS`, 10: SRAM word-address width; depth is 2^MEMADDRBITS words.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `mem_addr` in 32: byte address; sampled only in the cycle a request is accepted; word index = `mem_addr[MEMADDRBITS+1:2]`.
- `mem_datain` in 32: write data, one word per cycle during a write burst.
- `mem_rdreq` in 1: read-burst request pulse.
- `mem_wrreq` in 1: write-burst request pulse.
- `mem_out` out 32: read data; 0 whenever `mem_valid`=0.
- `mem_valid` out 1: `mem_out` carries a burst word this cycle.
- `mem_burstlen` out 16: constant `BURSTLEN`.
- `mem_busy` out 1: a burst is in progress; requests are not accepted.
- `mem_err` out 1: sticky; set when a request is dropped; cleared only by reset.

## Operation
- States: IDLE, RLAT, RBURST, WBURST. `mem_busy` = (state != IDLE), registered.
- **IDLE, `mem_wrreq`=1:**
  - Latch word index A into `wptr`.
  - Write `mem_datain` to SRAM[A] in this same cycle.
  - Set `cnt`=1 and go to WBURST; if `BURSTLEN`=1, stay in IDLE.
- **IDLE, `mem_rdreq`=1 (and `mem_wrreq`=0):**
  - Latch A into `rptr`.
  - Set `lat`=1 and go to RLAT.
- **IDLE, both requests in the same cycle:** the write is served, the read is dropped, and `mem_err` is set.
- **RLAT:**
  - Issue the SRAM read of `rptr` once `lat` = `READ_LAT`-1, then advance `rptr`.
  - Go to RBURST so the first word appears in cycle T+`READ_LAT`.
- **RBURST:**
  - Each cycle: `mem_valid`=1, `mem_out`=SRAM data, read the next address, `cnt`++.
  - After word `BURSTLEN`, return to IDLE.
- **WBURST:**
  - Each cycle: write `mem_datain` to SRAM[`wptr`], then `wptr`++ and `cnt`++.
  - After word `BURSTLEN`, return to IDLE.
- **Address arithmetic:** `rptr`/`wptr` are MEMADDRBITS wide and wrap modulo depth. A burst crossing the top address continues at 0. Address bits above MEMADDRBITS+1 are ignored (aliasing).
- `cnt` is 16 bits and compares against `BURSTLEN`.
- Any request seen while `mem_busy`=1 is ignored and sets `mem_err`. An in-flight burst is never disturbed.
- **Reset mid-burst:**
  - State returns to IDLE; all outputs go to their reset values.
  - SRAM contents are undefined after reset (not cleared).
- **Reset values:**
  - `mem_out`=0, `mem_valid`=0, `mem_busy`=0, `mem_err`=0.
  - `mem_burstlen`=`BURSTLEN`.

## Timing
- **Read request in cycle T:**
  - `mem_valid` is high in cycles T+`READ_LAT` .. T+`READ_LAT`+`BURSTLEN`-1, returning word A+k at cycle T+`READ_LAT`+k.
  - `mem_busy` is high T+1 .. T+`READ_LAT`+`BURSTLEN`-1.
  - A new request is accepted at T+`READ_LAT`+`BURSTLEN`.
- **Write request in cycle T:**
  - Word k (`mem_datain` at cycle T+k) is stored at A+k.
  - `mem_busy` is high T+1 .. T+`BURSTLEN`-1.
  - A new request is accepted at T+`BURSTLEN`.
- **Read-after-write:** a read accepted after a write completes returns the newly written data; there is no hazard window.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `dcache_pkg`: `ADDRBITS`=32, `DATABITS`=32, and the state encoding (IDLE=2'b00, RLAT=2'b01, RBURST=2'b10, WBURST=2'b11).
- Sub-module `mem_sram`:
  - Single-port synchronous RAM, 2^MEMADDRBITS x 32.
  - Write-first; registered read, 1-cycle latency.
  - Port arbitration between the read and write paths is done by the FSM.
- The top level holds the FSM, pointers, counters and output registers.

## Test plan
- **Reset:** assert `reset_n`=0 mid-RBURST -> `mem_valid`=0, `mem_busy`=0, `mem_err`=0 immediately; the next `mem_rdreq` is accepted normally.
- **Write then read:**
  - Stimulus: `mem_wrreq` at address 0x40 with data 0x100..0x107, then `mem_rdreq` at 0x40 (`BURSTLEN`=8, `READ_LAT`=2).
  - Response: 8 `mem_valid` cycles starting exactly 2 cycles after the request, data 0x100..0x107.
- **Wrap-around:**
  - Stimulus: `MEMADDRBITS`=4, write burst at word 14 with data 0xA0..0xA7.
  - Response: words 14,15,0..5 hold 0xA0..0xA7; a read at word 0 returns 0xA2 first.
- **Busy drop:** `mem_rdreq` pulsed during WBURST -> ignored, `mem_err`=1 sticky, stored write data intact.
- **Simultaneous requests:** `mem_rdreq`=`mem_wrreq`=1 in IDLE -> write performed, no `mem_valid`, `mem_err`=1.
- **Back-to-back reads:**
  - Stimulus: next `mem_rdreq` issued in the cycle after the last `mem_valid` (the cache line fill pattern), 4 bursts total.
  - Response: 32 correct words, `mem_err`=0.
